operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Upstream feeder for the polynomial compute block.
- Latches four operands (A, B, C, X) on a single start pulse and replays them serially over the compute block's Go/DataIn load handshake, in order A, B, C, X.
- Waits for ResultValid, captures DataResult, and reports done or timeout.
- Replaces manual KEY[1]/SW driving with a deterministic, repeatable sequence.

Parameters:
- DATA_W, 8, width of operands and result.
- GO_HIGH_CYCLES, 2, cycles go is held high per operand (>=1).
- GO_LOW_CYCLES, 2, cycles go is held low after each operand before the next is presented (>=1).
- TIMEOUT_CYCLES, 255, max cycles to wait for result_valid_in after the X operand (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- op_a, op_b, op_c, op_x  in  DATA_W each  operands, sampled on the accepting edge.
- go  out  1  Go to the compute block.
- data_out  out  DATA_W  DataIn to the compute block.
- result_in  in  DATA_W  DataResult from the compute block.
- result_valid_in  in  1  ResultValid from the compute block.
- busy  out  1  high while a sequence is in progress.
- result  out  DATA_W  captured result, held until the next accepted start.
- done  out  1  one-cycle pulse at sequence end.
- timeout  out  1  level; set with done on timeout, cleared on next accepted start.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; go=0, data_out=0, busy=0, result=0, done=0, timeout=0; operand regs=0; counters=0. Reset mid-sequence drops go in the same instant; no partial operand is completed.
- All outputs are registered.
- States: IDLE, SETUP, GO_HI, GO_LO, WAIT_RES, SETTLE, DONE. A 2-bit index idx selects A/B/C/X.
- IDLE:
  - start=1 -> latch op_a..op_x, idx=0, clear timeout, go to SETUP.
  - busy rises on the next edge.
- SETUP (1 cycle): data_out=operand[idx], go=0. -> GO_HI.
- GO_HI: go=1 for exactly GO_HIGH_CYCLES cycles; data_out held stable. -> GO_LO.
- GO_LO: go=0 for exactly GO_LOW_CYCLES cycles; data_out held stable.
  - If idx<3: idx+1, -> SETUP.
  - If idx=3: -> WAIT_RES.
- Timing: data_out changes only on entry to SETUP, so it is stable at least 1 cycle before and through every go-high cycle.
- Per-operand cost is 1+GO_HIGH_CYCLES+GO_LOW_CYCLES cycles; defaults give 20 cycles from SETUP(A) to WAIT_RES entry.
- WAIT_RES: the wait counter starts at 0 and increments each cycle.
  - result_valid_in=1 -> SETTLE. Valid takes priority if it arrives on the same cycle the counter hits TIMEOUT_CYCLES-1.
  - Counter reaches TIMEOUT_CYCLES-1 without valid -> DONE with timeout=1, result=0.
- SETTLE (1 cycle): result <= result_in, which covers the compute block's registered result lagging its valid. -> DONE.
- DONE (1 cycle): done=1, busy=1. -> IDLE (busy=0 next).
- start while busy, including in DONE, is ignored and not queued.
- Operand input changes after acceptance have no effect.
- Counters saturate-free: widths are sized by $clog2(max(param)+1); no wrap within a phase.
- result_valid_in outside WAIT_RES is ignored.

Optional Feature:
- Macro: OPERAND_SEQUENCER_STATS_EN.
- Defined: adds outputs run_count[15:0] (increments on every non-timeout done) and timeout_count[7:0] (increments on every timeout done).
  - Both are reset to 0 by reset.
  - Both saturate at all-ones.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package operand_sequencer_pkg holds:
  - the state enum (IDLE..DONE), 3 bits;
  - operand index constants IDX_A=0, IDX_B=1, IDX_C=2, IDX_X=3;
  - default parameter values.
- Sub-module go_phase_timer: loadable down-counter with terminal-count flag, reused for the GO_HI, GO_LO and WAIT_RES phases.

Test Plan:
- Reset during GO_HI of operand B (reset pulse high 1 cycle) -> go=0 and busy=0 immediately; after release, start with A=5, B=2, C=9, X=3 runs a clean full sequence.
- Defaults, start with A=5, B=2, C=9, X=3; compute model asserts result_valid_in=1 on cycle 3 of WAIT_RES and presents result_in=0x3A on the following cycle:
  - data_out is seen as 5, 2, 9, 3, each stable across 2 go-high cycles;
  - go pulses exactly 4 times;
  - done pulses once, result=0x3A, timeout=0.
- start re-asserted every cycle during a sequence -> only one sequence runs; the second start is accepted only after busy falls.
- result_valid_in never asserted, TIMEOUT_CYCLES=10 -> done exactly 10 cycles after WAIT_RES entry, timeout=1, result=0; timeout clears on the next start.
- Valid and timeout in the same cycle (valid on wait cycle 9, TIMEOUT_CYCLES=10) -> SETTLE path taken, timeout=0, result captured.
- With OPERAND_SEQUENCER_STATS_EN: 3 good runs plus 1 timeout -> run_count=3, timeout_count=1.

Source files
------------

// File: rtl/operand_sequencer_pkg.sv
// Shared types and defaults for the operand sequencer that feeds the polynomial compute block.
package operand_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    GO_HI    = 3'd2,
    GO_LO    = 3'd3,
    WAIT_RES = 3'd4,
    SETTLE   = 3'd5,
    DONE     = 3'd6
  } seq_state_e;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_X = 2'd3;

  localparam int DEF_DATA_W         = 8;
  localparam int DEF_GO_HIGH_CYCLES = 2;
  localparam int DEF_GO_LOW_CYCLES  = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/operand_sequencer_go_phase_timer.sv
// Loadable down-counter; tc is high once the loaded phase length has elapsed.
module go_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/operand_sequencer.sv
// Latches A/B/C/X on start and replays them over the Go/DataIn handshake, then waits for the result.
// Optional OPERAND_SEQUENCER_STATS_EN adds saturating run_count / timeout_count outputs.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int GO_HIGH_CYCLES = DEF_GO_HIGH_CYCLES,
  parameter int GO_LOW_CYCLES  = DEF_GO_LOW_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] op_c,
  input  logic [DATA_W-1:0] op_x,
  output logic              go,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] result_in,
  input  logic              result_valid_in,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              timeout
`ifdef OPERAND_SEQUENCER_STATS_EN
  ,
  output logic [15:0]       run_count,
  output logic [7:0]        timeout_count
`endif
);

  localparam int CNT_W = $clog2(max3(GO_HIGH_CYCLES, GO_LOW_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HI_LOAD   = CNT_W'(GO_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LO_LOAD   = CNT_W'(GO_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e        state, next_state;
  logic [1:0]        idx, idx_d;
  logic [DATA_W-1:0] a_q, b_q, c_q, x_q;
  logic [DATA_W-1:0] data_d, result_d;
  logic              go_d, busy_d, done_d, timeout_d, accept;
  logic              timer_load, timer_tc;
  logic [CNT_W-1:0]  timer_value;

  go_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .tc         (timer_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The timer is reloaded on entry to each timed phase, so tc marks that phase's last cycle.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE:     if (start) next_state = SETUP;
      SETUP: begin
        next_state  = GO_HI;
        timer_load  = 1'b1;
        timer_value = HI_LOAD;
      end
      GO_HI: if (timer_tc) begin
        next_state  = GO_LO;
        timer_load  = 1'b1;
        timer_value = LO_LOAD;
      end
      GO_LO: if (timer_tc) begin
        if (idx == IDX_X) begin
          next_state  = WAIT_RES;
          timer_load  = 1'b1;
          timer_value = WAIT_LOAD;
        end else begin
          next_state = SETUP;
        end
      end
      WAIT_RES: begin
        if (result_valid_in)  next_state = SETTLE;
        else if (timer_tc)    next_state = DONE;
      end
      SETTLE:   next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && start;
    go_d      = (next_state == GO_HI);
    busy_d    = (next_state != IDLE);
    done_d    = (next_state == DONE);
    idx_d     = idx;
    data_d    = data_out;
    timeout_d = timeout;
    result_d  = result;
    if (accept) begin
      idx_d     = IDX_A;
      data_d    = op_a;
      timeout_d = 1'b0;
      result_d  = '0;
    end else if (state == GO_LO && timer_tc && idx != IDX_X) begin
      idx_d = idx + 2'd1;
      case (idx_d)
        IDX_A:   data_d = a_q;
        IDX_B:   data_d = b_q;
        IDX_C:   data_d = c_q;
        default: data_d = x_q;
      endcase
    end
    if (state == WAIT_RES && !result_valid_in && timer_tc) begin
      timeout_d = 1'b1;
      result_d  = '0;
    end
    // The compute block's result register lags its valid by a cycle, so capture one cycle later.
    if (state == SETTLE) result_d = result_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= IDX_A;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      x_q      <= '0;
      data_out <= '0;
      go       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      result   <= '0;
    end else begin
      if (accept) begin
        a_q <= op_a;
        b_q <= op_b;
        c_q <= op_c;
        x_q <= op_x;
      end
      idx      <= idx_d;
      data_out <= data_d;
      go       <= go_d;
      busy     <= busy_d;
      done     <= done_d;
      timeout  <= timeout_d;
      result   <= result_d;
    end
  end

`ifdef OPERAND_SEQUENCER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_count     <= '0;
      timeout_count <= '0;
    end else if (done_d) begin
      if (timeout_d) begin
        if (timeout_count != '1) timeout_count <= timeout_count + 8'd1;
      end else begin
        if (run_count != '1) run_count <= run_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: directed scenarios plus randomized runs against a timing model.
module tb_operand_sequencer;

  localparam int DW = 8;
  localparam int T  = 10;
  // Model: each operand costs 1 setup + 2 high + 2 low cycles, so WAIT_RES starts 20 samples after accept.
  localparam int WAIT_START = 20;

  logic          clk = 1'b0;
  logic          reset, start, go, busy, done, timeout, result_valid_in;
  logic [DW-1:0] op_a, op_b, op_c, op_x, data_out, result_in, result;
`ifdef OPERAND_SEQUENCER_STATS_EN
  logic [15:0]   run_count;
  logic [7:0]    timeout_count;
`endif

  int checks = 0;
  int passed = 0;
  int exp_runs = 0;
  int exp_timeouts = 0;

  always #5 clk = ~clk;

  operand_sequencer #(
    .DATA_W(DW), .GO_HIGH_CYCLES(2), .GO_LOW_CYCLES(2), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .op_a            (op_a),
    .op_b            (op_b),
    .op_c            (op_c),
    .op_x            (op_x),
    .go              (go),
    .data_out        (data_out),
    .result_in       (result_in),
    .result_valid_in (result_valid_in),
    .busy            (busy),
    .result          (result),
    .done            (done),
    .timeout         (timeout)
`ifdef OPERAND_SEQUENCER_STATS_EN
    ,
    .run_count       (run_count),
    .timeout_count   (timeout_count)
`endif
  );

  // Runs one sequence; valid_k < 0 means the compute model never answers.
  task automatic run_sequence(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] c, input logic [DW-1:0] x,
                              input int valid_k, input logic [DW-1:0] res,
                              input bit hold_start, input string tag);
    logic [DW-1:0] ops [4];
    logic [DW-1:0] res_seen, exp_res;
    logic          to_seen, busy_at_done, busy_after, busy_after2, go_prev;
    int            exp_done, done_at, done_cnt, go_rises, bad_data;
    ops = '{a, b, c, x};
    exp_done = (valid_k >= 0) ? WAIT_START + 2 + valid_k : WAIT_START + T;
    exp_res  = (valid_k >= 0) ? res : '0;
    done_at = -1; done_cnt = 0; go_rises = 0; bad_data = 0; go_prev = 1'b0;
    res_seen = '0; to_seen = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1; busy_after2 = 1'b0;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; op_c = c; op_x = x;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL %s accept: timeout=%0b busy=%0b, required timeout=0 busy=1", tag, timeout, busy);
    else passed++;
    for (int s = 0; s < 80; s++) begin
      if (s < WAIT_START && data_out !== ops[s/5]) bad_data++;
      if (go && !go_prev) go_rises++;
      go_prev = go;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = s; res_seen = result; to_seen = timeout; busy_at_done = busy;
        end
      end
      if (done_at >= 0 && s == done_at + 1) busy_after = busy;
      if (done_at >= 0 && s == done_at + 2) begin
        busy_after2 = busy;
        break;
      end
      op_a = DW'($urandom); op_b = DW'($urandom); op_c = DW'($urandom); op_x = DW'($urandom);
      result_valid_in = (valid_k >= 0 && s == WAIT_START + valid_k) || (s == 7);
      result_in = (valid_k >= 0 && s == WAIT_START + 1 + valid_k) ? res : DW'($urandom);
      @(negedge clk);
    end
    result_valid_in = 1'b0;
    start = 1'b0;
    if (valid_k >= 0) exp_runs++; else exp_timeouts++;
    checks++;
    if (done_at != exp_done)
      $display("[TB] FAIL %s done_time: got sample %0d, required %0d", tag, done_at, exp_done);
    else passed++;
    checks++;
    if (done_cnt != 1) $display("[TB] FAIL %s done_pulses: got %0d, required 1", tag, done_cnt);
    else passed++;
    checks++;
    if (go_rises != 4) $display("[TB] FAIL %s go_pulses: got %0d, required 4", tag, go_rises);
    else passed++;
    checks++;
    if (bad_data != 0) $display("[TB] FAIL %s data_out_seq: %0d bad samples, required 0", tag, bad_data);
    else passed++;
    checks++;
    if (res_seen !== exp_res) $display("[TB] FAIL %s result: got %0h, required %0h", tag, res_seen, exp_res);
    else passed++;
    checks++;
    if (to_seen !== (valid_k < 0)) $display("[TB] FAIL %s timeout: got %0b, required %0b", tag, to_seen, valid_k < 0);
    else passed++;
    checks++;
    if (busy_at_done !== 1'b1 || busy_after !== 1'b0 || busy_after2 !== 1'(hold_start))
      $display("[TB] FAIL %s busy_tail: got %0b%0b%0b, required 10%0b", tag,
               busy_at_done, busy_after, busy_after2, hold_start);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; result_valid_in = 1'b0; result_in = '0;
    op_a = '0; op_b = '0; op_c = '0; op_x = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({go, busy, done, timeout} !== 4'b0000 || data_out !== '0 || result !== '0)
      $display("[TB] FAIL reset_state: go/busy/done/timeout=%b data_out=%0h result=%0h, required 0000/0/0",
               {go, busy, done, timeout}, data_out, result);
    else passed++;
`ifdef OPERAND_SEQUENCER_STATS_EN
    checks++;
    if (run_count !== 16'd0 || timeout_count !== 8'd0)
      $display("[TB] FAIL reset_stats: run=%0d timeout=%0d, required 0/0", run_count, timeout_count);
    else passed++;
`endif
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op_a = 8'd5; op_b = 8'd2; op_c = 8'd9; op_x = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (go !== 1'b1 || data_out !== 8'd2)
      $display("[TB] FAIL mid_go_b: go=%0b data_out=%0h, required 1/2", go, data_out);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (go !== 1'b0 || busy !== 1'b0 || data_out !== '0)
      $display("[TB] FAIL async_reset: go=%0b busy=%0b data_out=%0h, required 0/0/0", go, busy, data_out);
    else passed++;
    #10 reset = 1'b0;
    run_sequence(8'd5, 8'd2, 8'd9, 8'd3, 2, 8'h3A, 1'b0, "post_reset");
  endtask

  task automatic test_directed();
    run_sequence(8'd5, 8'd2, 8'd9, 8'd3, 3, 8'h3A, 1'b0, "directed");
  endtask

  task automatic test_timeout();
    run_sequence(8'h11, 8'h22, 8'h33, 8'h44, -1, 8'h00, 1'b0, "timeout");
    run_sequence(8'h55, 8'h66, 8'h77, 8'h88, 0, 8'hC3, 1'b0, "after_timeout");
  endtask

  task automatic test_valid_at_timeout();
    run_sequence(8'hA1, 8'hB2, 8'hC3, 8'hD4, T - 1, 8'h5E, 1'b0, "valid_at_limit");
  endtask

  task automatic test_back_to_back();
    int waited;
    run_sequence(8'h01, 8'h02, 8'h03, 8'h04, 4, 8'h99, 1'b1, "start_spam");
    waited = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        waited = n;
        break;
      end
    end
    exp_timeouts++;
    checks++;
    if (waited != WAIT_START + T || timeout !== 1'b1)
      $display("[TB] FAIL second_run: done after %0d timeout=%0b, required %0d/1", waited, timeout, WAIT_START + T);
    else passed++;
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 8; i++) begin
      k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, T - 1));
      run_sequence(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                   k, DW'($urandom), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_directed();
    test_timeout();
    test_valid_at_timeout();
    test_back_to_back();
    test_random();
`ifdef OPERAND_SEQUENCER_STATS_EN
    checks++;
    if (run_count !== 16'(exp_runs) || timeout_count !== 8'(exp_timeouts))
      $display("[TB] FAIL stats: run=%0d timeout=%0d, required %0d/%0d",
               run_count, timeout_count, exp_runs, exp_timeouts);
    else passed++;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
